// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared processor types and constants used by the data-memory arbiter
package arm_pkg;

  // dmem word-address width (byte address bits [8:3])
  localparam int DM_AW = 6;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DBG_LOCK = 1'b1
  } dmem_arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - debug starvation counter, built only with DMEM_ARB_STARVE_EN
`ifdef DMEM_ARB_STARVE_EN
module arb_wait_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waitInc,
  input  logic waitClr,
  output logic atLimit
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] waitCount;

  // Count cycles the debug port spends losing arbitration; saturate rather than wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCount <= 8'd0;
    end else if (waitClr) begin
      waitCount <= 8'd0;
    end else if (waitInc && (waitCount != 8'hFF)) begin
      waitCount <= waitCount + 8'd1;
    end
  end

  assign atLimit = (waitCount >= LIMIT);

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter for single-port dmem; optional DMEM_ARB_STARVE_EN anti-starvation
module dmem_arbiter
  import arm_pkg::*;
#(
  parameter int N        = 64,
  parameter int AW       = DM_AW,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic          cpu_gnt,
  output logic [N-1:0]  cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [N-1:0]  dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [N-1:0]  dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [N-1:0]  mem_rdata
);

  dmem_arb_state_t state;
  dmem_arb_state_t nextState;

  logic cpuGrant;
  logic dbgGrant;
  logic starveGrant;

  // CPU byte address: only the word index matters, low and high bits are dropped
  logic unusedAddrBits;
  assign unusedAddrBits = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};

`ifdef DMEM_ARB_STARVE_EN
  logic waitInc;
  assign waitInc = (state == IDLE) & dbg_req & ~dbgGrant;

  arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) uWaitCounter (
    .clk    (clk),
    .reset  (reset),
    .waitInc(waitInc),
    .waitClr(dbgGrant),
    .atLimit(starveGrant)
  );
`else
  // Strict CPU priority: the starvation limit has no effect in this build
  logic [31:0] unusedMaxWait;
  assign unusedMaxWait = MAX_WAIT;
  assign starveGrant   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state: lock is taken only on a granted debug beat and dropped on its last beat or release
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (dbgGrant && dbg_lock) nextState = DBG_LOCK;
      DBG_LOCK: if (!dbg_req || !dbg_lock) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Grant decode from registered state and current requests; nothing is granted while in reset
  always_comb begin
    cpuGrant = 1'b0;
    dbgGrant = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (starveGrant && dbg_req) begin
            dbgGrant = 1'b1;
          end else if (cpu_req) begin
            cpuGrant = 1'b1;
          end else if (dbg_req) begin
            dbgGrant = 1'b1;
          end
        end
        DBG_LOCK: dbgGrant = dbg_req;
        default:  ;
      endcase
    end
  end

  // Steer the granted port onto the memory bus; idle bus drives zeros
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpuGrant) begin
      mem_addr  = cpu_addr[AW+2:3];
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end else if (dbgGrant) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
    end
  end

  assign cpu_gnt   = cpuGrant;
  assign dbg_gnt   = dbgGrant;
  assign cpu_stall = cpu_req & ~cpuGrant;
  assign cpu_rdata = cpuGrant ? mem_rdata : '0;

  // Register debug read data at the end of each debug read beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbgGrant & ~dbg_we;
      if (dbgGrant && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule
